// File: rtl/qenc_pkg.sv
// Shared quadrature-encoder definitions: FSM states, direction encoding,
// rest positions and the Gray-code step function used by the generator.
package qenc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EDGE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Direction encoding matches the front-panel decoder's direction output.
  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // Detent rest positions, AB packed as {a, b}.
  localparam logic [1:0] AB_REST_00 = 2'b00;
  localparam logic [1:0] AB_REST_11 = 2'b11;

  // One Gray transition. CW: 00->10->11->01->00, CCW is the reverse walk.
  function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic dir);
    logic [1:0] nxt;
    nxt = 2'b00;
    case (dir)
      DIR_CW: begin
        case (ab)
          2'b00:   nxt = 2'b10;
          2'b10:   nxt = 2'b11;
          2'b11:   nxt = 2'b01;
          default: nxt = 2'b00;
        endcase
      end
      DIR_CCW: begin
        case (ab)
          2'b00:   nxt = 2'b01;
          2'b01:   nxt = 2'b11;
          2'b11:   nxt = 2'b10;
          default: nxt = 2'b00;
        endcase
      end
      default: nxt = ab;
    endcase
    return nxt;
  endfunction

  // A transition landing here completes a detent.
  function automatic logic is_rest(input logic [1:0] ab);
    return (ab == AB_REST_00) || (ab == AB_REST_11);
  endfunction

endpackage

// File: rtl/quad_enc_gen_if.sv
// Command/status bundle for the quadrature generator.
// QENC_GEN_POS_EN adds the absolute detent position output.
interface quad_enc_gen_if #(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned PER_W = 16
) ();

  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_dir;
  logic [CNT_W-1:0] i_cmd_detents;
  logic [PER_W-1:0] i_step_period;
  logic             i_abort;
  logic             o_enc_a;
  logic             o_enc_b;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_remaining;
`ifdef QENC_GEN_POS_EN
  logic [15:0]      o_position;

  modport master (
    output i_cmd_valid, i_cmd_dir, i_cmd_detents, i_step_period, i_abort,
    input  o_cmd_ready, o_enc_a, o_enc_b, o_busy, o_done, o_remaining, o_position
  );

  modport slave (
    input  i_cmd_valid, i_cmd_dir, i_cmd_detents, i_step_period, i_abort,
    output o_cmd_ready, o_enc_a, o_enc_b, o_busy, o_done, o_remaining, o_position
  );
`else
  modport master (
    output i_cmd_valid, i_cmd_dir, i_cmd_detents, i_step_period, i_abort,
    input  o_cmd_ready, o_enc_a, o_enc_b, o_busy, o_done, o_remaining
  );

  modport slave (
    input  i_cmd_valid, i_cmd_dir, i_cmd_detents, i_step_period, i_abort,
    output o_cmd_ready, o_enc_a, o_enc_b, o_busy, o_done, o_remaining
  );
`endif

endinterface

// File: rtl/qenc_step_timer.sv
// Step period counter: holds the latched period, counts while enabled and
// flags the last cycle of each period.
module qenc_step_timer #(
  parameter int unsigned PER_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             load,
  input  logic [PER_W-1:0] period,
  input  logic             clear,
  input  logic             en,
  output logic             tc_c
);

  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] cnt_q;

  // Terminal count; period is never below 2 so period-1 cannot underflow.
  assign tc_c = en && (cnt_q == (per_q - PER_W'(1)));

  // Period latch and counter; the counter restarts after each terminal count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      per_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        per_q <= period;
      end
      if (clear) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= tc_c ? '0 : cnt_q + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature A/B generator: emits Gray-coded detents for the front-panel
// decoder. QENC_GEN_POS_EN adds a signed 16-bit absolute position counter.
module quad_enc_gen
  import qenc_pkg::*;
#(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned PER_W   = 16,
  parameter int unsigned MIN_PER = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  quad_enc_gen_if.slave bus
);

  state_t           state, state_nxt;
  logic [1:0]       ab_q, ab_nxt;
  logic             dir_q, dir_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic             abort_q, abort_nxt;
  logic             ready_q, ready_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             tmr_load, tmr_clear, tmr_en, tmr_tc_c;
  logic [PER_W-1:0] per_clamped;
`ifdef QENC_GEN_POS_EN
  logic [15:0]      pos_q, pos_nxt;
`endif

  // Requests below the floor are raised to it.
  assign per_clamped = (bus.i_step_period < PER_W'(MIN_PER)) ? PER_W'(MIN_PER)
                                                             : bus.i_step_period;

  qenc_step_timer #(.PER_W(PER_W)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load   (tmr_load),
    .period (per_clamped),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .tc_c   (tmr_tc_c)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath updates; status outputs decode the next state.
  always_comb begin
    state_nxt = state;
    ab_nxt    = ab_q;
    dir_nxt   = dir_q;
    rem_nxt   = rem_q;
    abort_nxt = abort_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = (state == ST_WAIT);
`ifdef QENC_GEN_POS_EN
    pos_nxt   = pos_q;
`endif
    unique case (state)
      ST_IDLE: begin
        abort_nxt = 1'b0;
        if (bus.i_cmd_valid && ready_q) begin
          tmr_load  = 1'b1;
          tmr_clear = 1'b1;
          dir_nxt   = bus.i_cmd_dir;
          rem_nxt   = bus.i_cmd_detents;
          state_nxt = (bus.i_cmd_detents == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        abort_nxt = abort_q | bus.i_abort;
        if (tmr_tc_c) begin
          state_nxt = ST_EDGE;
        end
      end
      ST_EDGE: begin
        abort_nxt = abort_q | bus.i_abort;
        ab_nxt    = next_ab(ab_q, dir_q);
        state_nxt = ST_WAIT;
        // Landing on a rest position completes the detent; abort only stops here.
        if (is_rest(ab_nxt)) begin
          rem_nxt = rem_q - CNT_W'(1);
`ifdef QENC_GEN_POS_EN
          pos_nxt = (dir_q == DIR_CW) ? pos_q + 16'(1) : pos_q - 16'(1);
`endif
          if ((rem_nxt == '0) || abort_nxt) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        abort_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt  = (state_nxt == ST_WAIT) || (state_nxt == ST_EDGE);
    done_nxt  = (state_nxt == ST_DONE);
  end

  // Output and datapath registers; AB phase survives between commands.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ab_q    <= AB_REST_00;
      dir_q   <= DIR_CW;
      rem_q   <= '0;
      abort_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef QENC_GEN_POS_EN
      pos_q   <= '0;
`endif
    end else begin
      ab_q    <= ab_nxt;
      dir_q   <= dir_nxt;
      rem_q   <= rem_nxt;
      abort_q <= abort_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
`ifdef QENC_GEN_POS_EN
      pos_q   <= pos_nxt;
`endif
    end
  end

  assign bus.o_cmd_ready = ready_q;
  assign bus.o_enc_a     = ab_q[1];
  assign bus.o_enc_b     = ab_q[0];
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_remaining = rem_q;
`ifdef QENC_GEN_POS_EN
  assign bus.o_position  = pos_q;
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen with a loopback decoder model.
// Honours QENC_GEN_POS_EN for the position scenario.
module tb_quad_enc_gen;
  import qenc_pkg::*;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned PER_W = 16;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quad_enc_gen_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();

  quad_enc_gen #(.CNT_W(CNT_W), .PER_W(PER_W), .MIN_PER(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks;
  int passed;

  // Observation state, all owned by the single stimulus process.
  int               edge_n;
  logic [1:0]       prev_ab;
  logic [CNT_W-1:0] prev_rem;
  logic [1:0]       ab_seq[$];
  int               chg_edge[$];
  logic [CNT_W-1:0] rem_seq[$];
  int               hs_q[$];
  int               done_q[$];
  int               dec_data;
  logic             dec_dir;
  int               ready_bad;

  function automatic logic [31:0] ab_packed();
    logic [31:0] v;
    v = '0;
    foreach (ab_seq[i]) v = {v[29:0], ab_seq[i]};
    return v;
  endfunction

  function automatic logic [31:0] rem_packed();
    logic [31:0] v;
    v = '0;
    foreach (rem_seq[i]) v = (v << CNT_W) | 32'(rem_seq[i]);
    return v;
  endfunction

  function automatic int gap_bad(input int step);
    int n;
    n = 0;
    for (int i = 1; i < chg_edge.size(); i++)
      if (chg_edge[i] - chg_edge[i-1] != step) n++;
    return n;
  endfunction

  function automatic int first_lat();
    if (chg_edge.size() == 0 || hs_q.size() == 0) return -1;
    return chg_edge[0] - hs_q[0];
  endfunction

  // Sample outputs at the falling edge and run the loopback decoder model.
  task automatic observe();
    logic [1:0] ab;
    ab = {bus.o_enc_a, bus.o_enc_b};
    if (ab != prev_ab) begin
      ab_seq.push_back(ab);
      chg_edge.push_back(edge_n);
      if ((prev_ab == 2'b00 && ab == 2'b10) || (prev_ab == 2'b11 && ab == 2'b01)) begin
        dec_data++;
        dec_dir = DIR_CW;
      end else if ((prev_ab == 2'b00 && ab == 2'b01) || (prev_ab == 2'b11 && ab == 2'b10)) begin
        dec_data++;
        dec_dir = DIR_CCW;
      end
      prev_ab = ab;
    end
    if (bus.o_remaining != prev_rem) begin
      rem_seq.push_back(bus.o_remaining);
      prev_rem = bus.o_remaining;
    end
    if (bus.o_done) done_q.push_back(edge_n);
    if (bus.o_cmd_ready && (bus.o_busy || bus.o_done)) ready_bad++;
  endtask

  task automatic clk_step();
    logic take;
    take = bus.i_cmd_valid && bus.o_cmd_ready;
    @(posedge clk);
    edge_n++;
    if (take) hs_q.push_back(edge_n);
    @(negedge clk);
    observe();
  endtask

  task automatic clear_mon();
    ab_seq.delete();
    chg_edge.delete();
    rem_seq.delete();
    hs_q.delete();
    done_q.delete();
    prev_ab   = {bus.o_enc_a, bus.o_enc_b};
    prev_rem  = bus.o_remaining;
    dec_data  = 0;
    dec_dir   = 1'b0;
    ready_bad = 0;
  endtask

  task automatic send(input logic dir, input int det, input int per);
    bus.i_cmd_valid   = 1'b1;
    bus.i_cmd_dir     = dir;
    bus.i_cmd_detents = CNT_W'(det);
    bus.i_step_period = PER_W'(per);
    clk_step();
    bus.i_cmd_valid   = 1'b0;
  endtask

  task automatic run_until(input int n_done, input int budget, output bit ok);
    int i;
    i = 0;
    while (done_q.size() < n_done && i < budget) begin
      clk_step();
      i++;
    end
    ok = (done_q.size() >= n_done);
    repeat (3) clk_step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_enc_a !== 1'b0) $display("FAIL rst_enc_a: got %b want 0", bus.o_enc_a); else passed++;
    checks++; if (bus.o_enc_b !== 1'b0) $display("FAIL rst_enc_b: got %b want 0", bus.o_enc_b); else passed++;
    checks++; if (bus.o_cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.o_cmd_ready); else passed++;
    checks++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.o_busy); else passed++;
    checks++; if (bus.o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.o_done); else passed++;
    checks++; if (bus.o_remaining !== 5'd0) $display("FAIL rst_remaining: got %0d want 0", bus.o_remaining); else passed++;
`ifdef QENC_GEN_POS_EN
    checks++; if (bus.o_position !== 16'h0000) $display("FAIL rst_position: got %h want 0000", bus.o_position); else passed++;
`endif
    rst = 1'b1;
    clk_step();
  endtask

  task automatic test_cw3();
    bit ok;
    clear_mon();
    send(DIR_CW, 3, 4);
    run_until(1, 200, ok);
    checks++; if (!ok) $display("FAIL cw3_timeout: done count %0d want 1", done_q.size()); else passed++;
    checks++; if (ab_seq.size() !== 6) $display("FAIL cw3_ab_count: got %0d want 6", ab_seq.size()); else passed++;
    checks++; if (ab_packed() !== 32'hB4B) $display("FAIL cw3_ab_seq: got %h want 00000b4b", ab_packed()); else passed++;
    checks++; if (first_lat() !== 5) $display("FAIL cw3_first_latency: got %0d want 5", first_lat()); else passed++;
    checks++; if (gap_bad(5) !== 0) $display("FAIL cw3_spacing: %0d gaps not 5", gap_bad(5)); else passed++;
    checks++; if (rem_packed() !== ((32'd3 << 15) | (32'd2 << 10) | (32'd1 << 5)))
      $display("FAIL cw3_remaining_seq: got %h want 00018820", rem_packed()); else passed++;
    checks++; if (done_q.size() !== 1) $display("FAIL cw3_done_pulses: got %0d want 1", done_q.size()); else passed++;
    checks++; if (done_q.size() > 0 && chg_edge.size() == 6 && done_q[0] !== chg_edge[5])
      $display("FAIL cw3_done_edge: got %0d want %0d", done_q[0], chg_edge[5]); else passed++;
    checks++; if (dec_data !== 3) $display("FAIL cw3_dec_data: got %0d want 3", dec_data); else passed++;
    checks++; if (dec_dir !== 1'b0) $display("FAIL cw3_dec_dir: got %b want 0", dec_dir); else passed++;
    checks++; if (ready_bad !== 0) $display("FAIL cw3_ready_busy: got %0d overlaps want 0", ready_bad); else passed++;
  endtask

  task automatic test_ccw2();
    bit ok;
    clear_mon();
    send(DIR_CCW, 2, 2);
    run_until(1, 200, ok);
    checks++; if (!ok) $display("FAIL ccw2_timeout: done count %0d want 1", done_q.size()); else passed++;
    checks++; if (ab_seq.size() !== 4) $display("FAIL ccw2_ab_count: got %0d want 4", ab_seq.size()); else passed++;
    checks++; if (ab_packed() !== 32'h87) $display("FAIL ccw2_ab_seq: got %h want 00000087", ab_packed()); else passed++;
    checks++; if (gap_bad(3) !== 0) $display("FAIL ccw2_spacing: %0d gaps not 3", gap_bad(3)); else passed++;
    checks++; if (rem_packed() !== ((32'd2 << 10) | (32'd1 << 5)))
      $display("FAIL ccw2_remaining_seq: got %h want 00000820", rem_packed()); else passed++;
    checks++; if (dec_data !== 2) $display("FAIL ccw2_dec_data: got %0d want 2", dec_data); else passed++;
    checks++; if (dec_dir !== 1'b1) $display("FAIL ccw2_dec_dir: got %b want 1", dec_dir); else passed++;
  endtask

  task automatic test_zero_count();
    clear_mon();
    send(DIR_CW, 0, 4);
    checks++; if (bus.o_done !== 1'b1) $display("FAIL zero_done: got %b want 1", bus.o_done); else passed++;
    checks++; if (bus.o_cmd_ready !== 1'b0) $display("FAIL zero_ready_in_done: got %b want 0", bus.o_cmd_ready); else passed++;
    clk_step();
    checks++; if (bus.o_cmd_ready !== 1'b1) $display("FAIL zero_ready_back: got %b want 1", bus.o_cmd_ready); else passed++;
    repeat (4) clk_step();
    checks++; if (done_q.size() !== 1) $display("FAIL zero_done_pulses: got %0d want 1", done_q.size()); else passed++;
    checks++; if (ab_seq.size() !== 0) $display("FAIL zero_ab_change: got %0d changes want 0", ab_seq.size()); else passed++;
  endtask

  task automatic test_min_period();
    bit ok;
    clear_mon();
    send(DIR_CW, 1, 0);
    run_until(1, 100, ok);
    checks++; if (!ok) $display("FAIL per0_timeout: done count %0d want 1", done_q.size()); else passed++;
    checks++; if (ab_packed() !== 32'h4) $display("FAIL per0_ab_seq: got %h want 00000004", ab_packed()); else passed++;
    checks++; if (first_lat() !== 3) $display("FAIL per0_first_latency: got %0d want 3", first_lat()); else passed++;
    checks++; if (gap_bad(3) !== 0) $display("FAIL per0_spacing: %0d gaps not 3", gap_bad(3)); else passed++;
    clear_mon();
    send(DIR_CW, 1, 1);
    run_until(1, 100, ok);
    checks++; if (!ok) $display("FAIL per1_timeout: done count %0d want 1", done_q.size()); else passed++;
    checks++; if (ab_packed() !== 32'hB) $display("FAIL per1_ab_seq: got %h want 0000000b", ab_packed()); else passed++;
    checks++; if (first_lat() !== 3) $display("FAIL per1_first_latency: got %0d want 3", first_lat()); else passed++;
    checks++; if (gap_bad(3) !== 0) $display("FAIL per1_spacing: %0d gaps not 3", gap_bad(3)); else passed++;
  endtask

  task automatic test_abort();
    bit pulsed;
    int i;
    clear_mon();
    send(DIR_CW, 10, 2);
    pulsed = 1'b0;
    i = 0;
    while (done_q.size() == 0 && i < 300) begin
      // Seven changes seen: mid-way through detent 4.
      if (!pulsed && ab_seq.size() == 7) begin
        bus.i_abort = 1'b1;
        pulsed = 1'b1;
        clk_step();
        bus.i_abort = 1'b0;
      end else begin
        clk_step();
      end
      i++;
    end
    checks++; if (done_q.size() == 0) $display("FAIL abort_timeout: no done within 300 cycles"); else passed++;
    repeat (4) clk_step();
    checks++; if (ab_seq.size() !== 8) $display("FAIL abort_ab_count: got %0d want 8", ab_seq.size()); else passed++;
    checks++; if (ab_packed() !== 32'h4B4B) $display("FAIL abort_ab_seq: got %h want 00004b4b", ab_packed()); else passed++;
    checks++; if ({bus.o_enc_a, bus.o_enc_b} !== 2'b11) $display("FAIL abort_rest: got %b want 11", {bus.o_enc_a, bus.o_enc_b}); else passed++;
    checks++; if (bus.o_remaining !== 5'd6) $display("FAIL abort_remaining: got %0d want 6", bus.o_remaining); else passed++;
    checks++; if (done_q.size() !== 1) $display("FAIL abort_done_pulses: got %0d want 1", done_q.size()); else passed++;
    checks++; if (dec_data !== 4) $display("FAIL abort_dec_data: got %0d want 4", dec_data); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i;
    clear_mon();
    bus.i_cmd_valid   = 1'b1;
    bus.i_cmd_dir     = DIR_CW;
    bus.i_cmd_detents = CNT_W'(1);
    bus.i_step_period = PER_W'(2);
    i = 0;
    while (hs_q.size() < 2 && i < 200) begin
      clk_step();
      i++;
    end
    bus.i_cmd_valid = 1'b0;
    run_until(2, 200, ok);
    checks++; if (!ok || hs_q.size() < 2) $display("FAIL b2b_timeout: handshakes %0d dones %0d want 2 2", hs_q.size(), done_q.size()); else passed++;
    checks++; if (ready_bad !== 0) $display("FAIL b2b_ready_busy: got %0d overlaps want 0", ready_bad); else passed++;
    checks++; if (hs_q.size() >= 2 && done_q.size() >= 1 && hs_q[1] - done_q[0] !== 2)
      $display("FAIL b2b_second_accept: got %0d edges after done want 2", hs_q[1] - done_q[0]); else passed++;
    checks++; if (ab_packed() !== 32'h4B) $display("FAIL b2b_ab_seq: got %h want 0000004b", ab_packed()); else passed++;
    checks++; if (dec_data !== 2) $display("FAIL b2b_dec_data: got %0d want 2", dec_data); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send(DIR_CW, 3, 8);
    repeat (4) clk_step();
    checks++; if (bus.o_busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus.o_busy); else passed++;
    rst = 1'b0;
    #1;
    checks++; if ({bus.o_enc_a, bus.o_enc_b} !== 2'b00) $display("FAIL mid_ab: got %b want 00", {bus.o_enc_a, bus.o_enc_b}); else passed++;
    checks++; if (bus.o_cmd_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", bus.o_cmd_ready); else passed++;
    checks++; if (bus.o_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.o_busy); else passed++;
    checks++; if (bus.o_remaining !== 5'd0) $display("FAIL mid_remaining: got %0d want 0", bus.o_remaining); else passed++;
    repeat (3) clk_step();
    rst = 1'b1;
    repeat (3) clk_step();
    checks++; if (done_q.size() !== 0) $display("FAIL mid_done: got %0d pulses want 0", done_q.size()); else passed++;
  endtask

`ifdef QENC_GEN_POS_EN
  task automatic test_position();
    bit ok;
    clear_mon();
    send(DIR_CW, 5, 2);
    run_until(1, 300, ok);
    checks++; if (bus.o_position !== 16'h0005) $display("FAIL pos_after_cw: got %h want 0005", bus.o_position); else passed++;
    clear_mon();
    send(DIR_CCW, 7, 2);
    run_until(1, 300, ok);
    checks++; if (bus.o_position !== 16'hFFFE) $display("FAIL pos_after_ccw: got %h want fffe", bus.o_position); else passed++;
  endtask
`endif

  initial begin
    checks            = 0;
    passed            = 0;
    edge_n            = 0;
    rst               = 1'b0;
    bus.i_cmd_valid   = 1'b0;
    bus.i_cmd_dir     = 1'b0;
    bus.i_cmd_detents = '0;
    bus.i_step_period = '0;
    bus.i_abort       = 1'b0;
    @(negedge clk);
    test_reset();
    test_cw3();
    test_ccw2();
    test_zero_count();
    test_min_period();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef QENC_GEN_POS_EN
    test_position();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
